// File: rtl/forward_pkg.sv
// Shared types and width helpers for the forwarding-channel arbiter.
package forward_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   // A single requester still gets a one-bit tag so the payload format never changes.
   function automatic int tagWidth(input int numChan);
      return (numChan <= 1) ? 1 : clog2(numChan);
   endfunction

endpackage

// File: rtl/forward_rr_pick.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping around.
module forward_rr_pick
   import forward_pkg::*;
#(
   parameter int NUM_CHAN = 4,
   parameter int PTR_W    = tagWidth(NUM_CHAN)
) (
   input  logic [NUM_CHAN-1:0] req,
   input  logic [PTR_W-1:0]    ptr,
   output logic                any,
   output logic [PTR_W-1:0]    grant
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      any   = 1'b0;
      grant = '0;
      idx   = '0;
      for (int k = 0; k < NUM_CHAN; k++) begin
         idx = PTR_W'((int'(ptr) + k) % NUM_CHAN);
         if (!any && req[idx]) begin
            any   = 1'b1;
            grant = idx;
         end
      end
   end

endmodule

// File: rtl/forward_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake crossing channel, with lost-ack recovery.
module forward_arbiter
   import forward_pkg::*;
#(
   parameter int NUM_CHAN   = 4,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 1023
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic [NUM_CHAN-1:0]                         chanValid,
   input  logic [NUM_CHAN*DATA_WIDTH-1:0]              chanData,
   output logic [NUM_CHAN-1:0]                         chanAck,
   output logic [tagWidth(NUM_CHAN)+DATA_WIDTH-1:0]    xferData,
   output logic                                        xferReq,
   input  logic                                        xferAck,
   input  logic                                        timeoutClear,
   output logic                                        timeoutFlag,
   output logic [15:0]                                 xferCount
);

   localparam int TAG_WIDTH = tagWidth(NUM_CHAN);
   localparam int TIMER_W   = clog2(TIMEOUT);

   state_t                          state_q;
   logic                            ackMeta_q, ackSync_q;
   logic [TAG_WIDTH-1:0]            ptr_q;
   logic [TIMER_W-1:0]              timer_q;
   logic [TAG_WIDTH+DATA_WIDTH-1:0] xferData_q;
   logic                            xferReq_q;
   logic [NUM_CHAN-1:0]             chanAck_q;
   logic                            timeoutFlag_q;
   logic [15:0]                     xferCount_q;

   logic                            pickAny;
   logic [TAG_WIDTH-1:0]            pickGrant;
   logic [DATA_WIDTH-1:0]           chanWord [NUM_CHAN];
   logic                            timerExpired;

   forward_rr_pick #(
      .NUM_CHAN (NUM_CHAN),
      .PTR_W    (TAG_WIDTH)
   ) u_pick (
      .req   (chanValid),
      .ptr   (ptr_q),
      .any   (pickAny),
      .grant (pickGrant)
   );

   always_comb begin
      for (int i = 0; i < NUM_CHAN; i++) begin
         chanWord[i] = chanData[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign timerExpired = (timer_q == TIMER_W'(TIMEOUT - 1));

   // The timer also runs in IDLE while the far side disagrees, so a stale toggle left
   // over from a reset is eventually absorbed the same way as a lost acknowledge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         ackMeta_q     <= 1'b0;
         ackSync_q     <= 1'b0;
         ptr_q         <= '0;
         timer_q       <= '0;
         xferData_q    <= '0;
         xferReq_q     <= 1'b0;
         chanAck_q     <= '0;
         timeoutFlag_q <= 1'b0;
         xferCount_q   <= '0;
      end else begin
         ackMeta_q <= xferAck;
         ackSync_q <= ackMeta_q;
         chanAck_q <= '0;
         if (timeoutClear) timeoutFlag_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (ackSync_q != xferReq_q) begin
                  if (timerExpired) begin
                     timeoutFlag_q <= 1'b1;
                     xferReq_q     <= ackSync_q;
                     timer_q       <= '0;
                  end else begin
                     timer_q <= timer_q + TIMER_W'(1);
                  end
               end else if (pickAny) begin
                  xferData_q           <= {pickGrant, chanWord[pickGrant]};
                  xferReq_q            <= ~xferReq_q;
                  chanAck_q[pickGrant] <= 1'b1;
                  ptr_q                <= TAG_WIDTH'((int'(pickGrant) + 1) % NUM_CHAN);
                  timer_q              <= '0;
                  state_q              <= BUSY;
               end else begin
                  timer_q <= '0;
               end
            end
            BUSY: begin
               timer_q <= timer_q + TIMER_W'(1);
               if (ackSync_q == xferReq_q) begin
                  xferCount_q <= xferCount_q + 16'd1;
                  timer_q     <= '0;
                  state_q     <= IDLE;
               end else if (timerExpired) begin
                  timeoutFlag_q <= 1'b1;
                  xferReq_q     <= ackSync_q;
                  timer_q       <= '0;
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign chanAck     = chanAck_q;
   assign xferData    = xferData_q;
   assign xferReq     = xferReq_q;
   assign timeoutFlag = timeoutFlag_q;
   assign xferCount   = xferCount_q;

endmodule

// File: tb/tb_forward_arbiter.sv
// Directed bench for forward_arbiter with a toggle-returning far-side model.
module tb_forward_arbiter;

   localparam int K = 6;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [3:0]   chanValid = '0;
   logic [127:0] chanData = '0;
   logic [3:0]   chanAck;
   logic [33:0]  xferData;
   logic         xferReq;
   logic         xferAck = 1'b0;
   logic         timeoutClear = 1'b0;
   logic         timeoutFlag;
   logic [15:0]  xferCount;

   bit           farReset = 1'b0;
   bit           farEnable = 1'b1;
   logic         farReqM = 1'b0, farReqS = 1'b0;
   int           farDelay = 0;
   logic [33:0]  farCapt = '0;
   int           farCount = 0;

   int           nChecks = 0;
   int           nPass = 0;
   int           pulses [4];
   logic [3:0]   seenAck;

   forward_arbiter #(
      .NUM_CHAN   (4),
      .DATA_WIDTH (32),
      .TIMEOUT    (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .chanValid    (chanValid),
      .chanData     (chanData),
      .chanAck      (chanAck),
      .xferData     (xferData),
      .xferReq      (xferReq),
      .xferAck      (xferAck),
      .timeoutClear (timeoutClear),
      .timeoutFlag  (timeoutFlag),
      .xferCount    (xferCount)
   );

   always #5 clk = ~clk;

   // Far side: synchronise the request toggle, hold it K cycles, capture the word, return the toggle.
   always @(posedge clk) begin
      farReqM <= xferReq;
      farReqS <= farReqM;
      if (farReset) begin
         xferAck  <= 1'b0;
         farDelay <= 0;
         farReqM  <= 1'b0;
         farReqS  <= 1'b0;
      end else if (farEnable && (farReqS != xferAck)) begin
         if (farDelay == K - 1) begin
            xferAck  <= ~xferAck;
            farCapt  <= xferData;
            farCount <= farCount + 1;
            farDelay <= 0;
         end else begin
            farDelay <= farDelay + 1;
         end
      end else begin
         farDelay <= 0;
      end
   end

   task automatic tick();
      @(negedge clk);
      for (int c = 0; c < 4; c++) pulses[c] += int'(chanAck[c]);
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nChecks++;
      assert (observed === expected) nPass++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   task automatic applyStimulus(input logic [3:0] valid, input int slot, input logic [31:0] word);
      chanData[slot*32 +: 32] = word;
      chanValid = valid;
   endtask

   task automatic doReset(input bit withFar);
      reset = 1'b1;
      farReset = withFar;
      chanValid = '0;
      timeoutClear = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      farReset = 1'b0;
      tick();
   endtask

   task automatic waitGrant(input string tag, input int bound, output logic [3:0] ack);
      for (int n = 0; n < bound; n++) begin
         tick();
         if (chanAck != 4'b0) break;
      end
      ack = chanAck;
      checkOutput(tag, 64'(chanAck != 4'b0), 64'd1);
   endtask

   task automatic waitCount(input string tag, input logic [15:0] target, input int bound);
      for (int n = 0; n < bound && xferCount !== target; n++) tick();
      checkOutput(tag, 64'(xferCount), 64'(target));
   endtask

   task automatic waitFar(input string tag, input logic [33:0] target, input int bound);
      for (int n = 0; n < bound && farCapt !== target; n++) tick();
      checkOutput(tag, 64'(farCapt), 64'(target));
   endtask

   initial begin
      for (int c = 0; c < 4; c++) pulses[c] = 0;
      $display("[TB] start");

      // Reset state
      reset = 1'b1;
      farReset = 1'b1;
      repeat (3) tick();
      checkOutput("rst xferReq", 64'(xferReq), 64'd0);
      checkOutput("rst xferData", 64'(xferData), 64'd0);
      checkOutput("rst chanAck", 64'(chanAck), 64'd0);
      checkOutput("rst timeoutFlag", 64'(timeoutFlag), 64'd0);
      checkOutput("rst xferCount", 64'(xferCount), 64'd0);
      reset = 1'b0;
      farReset = 1'b0;
      tick();

      // Single channel
      applyStimulus(4'b0100, 2, 32'hDEADBEEF);
      waitGrant("t1 grant", 10, seenAck);
      checkOutput("t1 chanAck", 64'(seenAck), 64'h4);
      checkOutput("t1 xferData", 64'(xferData), {30'd0, 2'd2, 32'hDEADBEEF});
      checkOutput("t1 xferReq", 64'(xferReq), 64'd1);
      chanValid = '0;
      tick();
      checkOutput("t1 ack pulse", 64'(chanAck), 64'd0);
      waitCount("t1 count", 16'd1, 30);
      checkOutput("t1 far data", 64'(farCapt), {30'd0, 2'd2, 32'hDEADBEEF});
      checkOutput("t1 far count", 64'(farCount), 64'd1);

      // Fairness from reset
      doReset(1'b1);
      for (int c = 0; c < 4; c++) pulses[c] = 0;
      for (int c = 0; c < 4; c++) chanData[c*32 +: 32] = 32'hA0A0_0000 + 32'(c);
      chanValid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         waitGrant("t2 grant", 40, seenAck);
         checkOutput("t2 tag", 64'(xferData[33:32]), 64'(i % 4));
         checkOutput("t2 chanAck", 64'(seenAck), 64'(4'b0001 << (i % 4)));
      end
      chanValid = '0;
      waitCount("t2 count", 16'd8, 40);
      for (int c = 0; c < 4; c++) checkOutput("t2 pulses", 64'(pulses[c]), 64'd2);

      // Lost acknowledge with the clear racing the flag
      doReset(1'b1);
      farEnable = 1'b0;
      applyStimulus(4'b0001, 0, 32'h11111111);
      waitGrant("t3 grant", 10, seenAck);
      chanValid = '0;
      repeat (15) tick();
      checkOutput("t3 flag early", 64'(timeoutFlag), 64'd0);
      timeoutClear = 1'b1;
      tick();
      checkOutput("t3 flag set", 64'(timeoutFlag), 64'd1);
      checkOutput("t3 xferReq", 64'(xferReq), 64'd0);
      checkOutput("t3 count", 64'(xferCount), 64'd0);
      tick();
      checkOutput("t4 flag clear", 64'(timeoutFlag), 64'd0);
      timeoutClear = 1'b0;
      repeat (4) tick();
      farEnable = 1'b1;
      applyStimulus(4'b1000, 3, 32'hCAFEF00D);
      waitGrant("t3 regrant", 10, seenAck);
      checkOutput("t3 regrant ack", 64'(seenAck), 64'h8);
      checkOutput("t3 regrant data", 64'(xferData), {30'd0, 2'd3, 32'hCAFEF00D});
      chanValid = '0;
      waitCount("t3 count after", 16'd1, 30);
      checkOutput("t3 far data", 64'(farCapt), {30'd0, 2'd3, 32'hCAFEF00D});

      // Reset while a transfer is in flight; the far side still answers later
      doReset(1'b1);
      applyStimulus(4'b0010, 1, 32'h22222222);
      waitGrant("t5 grant", 10, seenAck);
      chanValid = '0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      applyStimulus(4'b0001, 0, 32'h33333333);
      waitGrant("t5 grant after", 60, seenAck);
      checkOutput("t5 ack after", 64'(seenAck), 64'h1);
      chanValid = '0;
      waitFar("t5 far data", {2'd0, 32'h33333333}, 80);
      applyStimulus(4'b0100, 2, 32'h44444444);
      waitGrant("t5 next grant", 80, seenAck);
      checkOutput("t5 next ack", 64'(seenAck), 64'h4);
      chanValid = '0;
      waitFar("t5 next far", {2'd2, 32'h44444444}, 80);
      repeat (20) tick();

      // Completion counter wrap
      force dut.xferCount_q = 16'hFFFF;
      tick();
      release dut.xferCount_q;
      tick();
      checkOutput("t6 preload", 64'(xferCount), 64'hFFFF);
      applyStimulus(4'b0001, 0, 32'h55555555);
      waitGrant("t6 grant", 20, seenAck);
      chanValid = '0;
      waitCount("t6 wrap", 16'h0000, 40);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
